ifetch_unit: RTL and testbench

IFETCH_UNIT -- requirements
Module: ifetch_unit

---
 rtl/ifetch_unit.sv | 118 +++++++++++
 tb/tb_ifetch_unit.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: a byte-addressed PC drives the instruction memory, and the
// returned word is registered into IR one cycle later. Supports stall, redirect and halt.
module ifetch_unit #(
  parameter logic [7:0] RESET_PC = 8'h00,
  parameter int         CNT_W    = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  output logic [7:0]       IADDR,
  input  logic [15:0]      IDATA,
  input  logic             STALL,
  input  logic             REDIRECT,
  input  logic [7:0]       REDIRECT_PC,
  input  logic             HALT,
  output logic [15:0]      IR,
  output logic [7:0]       IR_PC,
  output logic             IR_VALID,
  output logic             ALIGN_ERR,
  output logic             HALTED,
  output logic [CNT_W-1:0] FETCH_CNT,
  output logic [1:0]       DBG_STATE
);

  typedef enum logic [1:0] {
    ST_START  = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       pc_q, pc_d;
  logic [15:0]      ir_q, ir_d;
  logic [7:0]       ir_pc_q, ir_pc_d;
  logic             ir_valid_q, ir_valid_d;
  logic             align_err_q, align_err_d;
  logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;

  // Priority inside RUN: HALT > REDIRECT > STALL > normal fetch.
  // STALL is a plain hold request; there is no handshake on the IR side.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    ir_pc_d     = ir_pc_q;
    ir_valid_d  = ir_valid_q;
    align_err_d = 1'b0;
    fetch_cnt_d = fetch_cnt_q;

    case (state_q)
      ST_START: begin
        if (HALT) begin
          state_d    = ST_HALTED;
          ir_valid_d = 1'b0;
          ir_d       = 16'h0000;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (HALT) begin
          state_d    = ST_HALTED;
          ir_valid_d = 1'b0;
          ir_d       = 16'h0000;
        end else if (REDIRECT) begin
          pc_d        = {REDIRECT_PC[7:1], 1'b0};
          ir_d        = 16'h0000;
          ir_valid_d  = 1'b0;
          align_err_d = REDIRECT_PC[0];
        end else if (!STALL) begin
          ir_d       = IDATA;
          ir_pc_d    = pc_q;
          ir_valid_d = 1'b1;
          pc_d       = pc_q + 8'd2;
          if (fetch_cnt_q != {CNT_W{1'b1}}) begin
            fetch_cnt_d = fetch_cnt_q + CNT_W'(1);
          end
        end
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d = ST_START;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= ST_START;
      pc_q        <= {RESET_PC[7:1], 1'b0};
      ir_q        <= 16'h0000;
      ir_pc_q     <= 8'h00;
      ir_valid_q  <= 1'b0;
      align_err_q <= 1'b0;
      fetch_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      ir_pc_q     <= ir_pc_d;
      ir_valid_q  <= ir_valid_d;
      align_err_q <= align_err_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  // IADDR comes straight from the PC register so memory sees a glitch-free address.
  assign IADDR     = pc_q;
  assign IR        = ir_q;
  assign IR_PC     = ir_pc_q;
  assign IR_VALID  = ir_valid_q;
  assign ALIGN_ERR = align_err_q;
  assign HALTED    = (state_q == ST_HALTED);
  assign FETCH_CNT = fetch_cnt_q;
  assign DBG_STATE = state_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed vector table for the fetch/stall/redirect/halt sequences,
// then randomized stimulus against a step-level reference model.
module tb_ifetch_unit;

  logic        clk;
  logic        rst;
  logic [7:0]  iaddr;
  logic [15:0] idata;
  logic        stall;
  logic        redir;
  logic [7:0]  rpc;
  logic        halt;
  logic [15:0] ir;
  logic [7:0]  ir_pc;
  logic        ir_valid;
  logic        align_err;
  logic        halted;
  logic [15:0] fetch_cnt;
  logic [1:0]  dbg_state;

  logic [7:0]  iaddr2;
  logic [15:0] idata2;
  logic [15:0] ir2;
  logic [7:0]  ir_pc2;
  logic        ir_valid2, align_err2, halted2;
  logic [2:0]  fetch_cnt2;
  logic [1:0]  dbg_state2;

  logic [15:0] mem [128];

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  assign idata  = mem[iaddr[7:1]];
  assign idata2 = mem[iaddr2[7:1]];

  ifetch_unit #(.RESET_PC(8'h00), .CNT_W(16)) dut (
    .CLK(clk), .RESET(rst), .IADDR(iaddr), .IDATA(idata), .STALL(stall),
    .REDIRECT(redir), .REDIRECT_PC(rpc), .HALT(halt), .IR(ir), .IR_PC(ir_pc),
    .IR_VALID(ir_valid), .ALIGN_ERR(align_err), .HALTED(halted),
    .FETCH_CNT(fetch_cnt), .DBG_STATE(dbg_state)
  );

  // Narrow counter instance: same stimulus, exercises saturation quickly.
  ifetch_unit #(.RESET_PC(8'h00), .CNT_W(3)) dut_sat (
    .CLK(clk), .RESET(rst), .IADDR(iaddr2), .IDATA(idata2), .STALL(stall),
    .REDIRECT(redir), .REDIRECT_PC(rpc), .HALT(halt), .IR(ir2), .IR_PC(ir_pc2),
    .IR_VALID(ir_valid2), .ALIGN_ERR(align_err2), .HALTED(halted2),
    .FETCH_CNT(fetch_cnt2), .DBG_STATE(dbg_state2)
  );

  // ---------------- vector table ----------------
  typedef struct {
    logic        rst, stall, redir;
    logic [7:0]  rpc;
    logic        halt;
    logic [15:0] ir;
    logic [7:0]  ir_pc;
    logic        v, al, h;
    logic [7:0]  iaddr;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic s, input logic rd,
                              input logic [7:0] rp, input logic hl,
                              input logic [15:0] e_ir, input logic [7:0] e_pc,
                              input logic e_v, input logic e_al, input logic e_h,
                              input logic [7:0] e_ia, input logic [15:0] e_cnt);
    vec_t t;
    t.rst = r; t.stall = s; t.redir = rd; t.rpc = rp; t.halt = hl;
    t.ir = e_ir; t.ir_pc = e_pc; t.v = e_v; t.al = e_al; t.h = e_h;
    t.iaddr = e_ia; t.cnt = e_cnt;
    return t;
  endfunction

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic rd,
                       input logic [7:0] rp, input logic hl);
    rst = r; stall = s; redir = rd; rpc = rp; halt = hl;
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  int          m_pc;
  logic [15:0] m_ir;
  int          m_ir_pc;
  logic        m_v, m_al, m_started, m_halted;
  int          m_cnt;

  task automatic model_step(input logic r, input logic s, input logic rd,
                            input logic [7:0] rp, input logic hl);
    m_al = 1'b0;
    if (r) begin
      m_pc = 0; m_ir = 16'h0; m_ir_pc = 0; m_v = 1'b0;
      m_started = 1'b0; m_halted = 1'b0; m_cnt = 0;
    end else if (m_halted) begin
      // frozen until reset
    end else if (hl) begin
      m_halted = 1'b1; m_v = 1'b0; m_ir = 16'h0;
    end else if (!m_started) begin
      m_started = 1'b1;
    end else if (rd) begin
      m_pc = (rp / 2) * 2; m_ir = 16'h0; m_v = 1'b0; m_al = rp[0];
    end else if (!s) begin
      m_ir = mem[m_pc / 2]; m_ir_pc = m_pc; m_v = 1'b1;
      m_pc = (m_pc + 2) % 256;
      if (m_cnt < 65535) m_cnt++;
    end
  endtask

  // ---------------- test ----------------
  initial begin
    rst = 1'b1; stall = 1'b0; redir = 1'b0; rpc = 8'h00; halt = 1'b0;
    for (int k = 0; k < 128; k++) mem[k] = 16'h1000 + 16'(k);

    //               rst stl rdr rpc    hlt  ir        irpc   v  al h  iaddr  cnt
    tbl.push_back(mk(1, 0, 0, 8'h00, 0, 16'h0000, 8'h00, 0, 0, 0, 8'h00, 16'd0));
    tbl.push_back(mk(1, 1, 1, 8'h33, 1, 16'h0000, 8'h00, 0, 0, 0, 8'h00, 16'd0));
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 16'h0000, 8'h00, 0, 0, 0, 8'h00, 16'd0));
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 16'h1000, 8'h00, 1, 0, 0, 8'h02, 16'd1));
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 16'h1001, 8'h02, 1, 0, 0, 8'h04, 16'd2));
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 16'h1002, 8'h04, 1, 0, 0, 8'h06, 16'd3));
    tbl.push_back(mk(0, 1, 0, 8'h00, 0, 16'h1002, 8'h04, 1, 0, 0, 8'h06, 16'd3));
    tbl.push_back(mk(0, 1, 0, 8'h00, 0, 16'h1002, 8'h04, 1, 0, 0, 8'h06, 16'd3));
    tbl.push_back(mk(0, 1, 0, 8'h00, 0, 16'h1002, 8'h04, 1, 0, 0, 8'h06, 16'd3));
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 16'h1003, 8'h06, 1, 0, 0, 8'h08, 16'd4));
    tbl.push_back(mk(0, 1, 1, 8'h21, 0, 16'h0000, 8'h06, 0, 1, 0, 8'h20, 16'd4));
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 16'h1010, 8'h20, 1, 0, 0, 8'h22, 16'd5));
    tbl.push_back(mk(0, 0, 1, 8'hFC, 0, 16'h0000, 8'h20, 0, 0, 0, 8'hFC, 16'd5));
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 16'h107E, 8'hFC, 1, 0, 0, 8'hFE, 16'd6));
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 16'h107F, 8'hFE, 1, 0, 0, 8'h00, 16'd7));
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 16'h1000, 8'h00, 1, 0, 0, 8'h02, 16'd8));
    tbl.push_back(mk(0, 0, 1, 8'h41, 1, 16'h0000, 8'h00, 0, 0, 1, 8'h02, 16'd8));
    tbl.push_back(mk(0, 1, 1, 8'h40, 0, 16'h0000, 8'h00, 0, 0, 1, 8'h02, 16'd8));
    tbl.push_back(mk(0, 0, 0, 8'h00, 1, 16'h0000, 8'h00, 0, 0, 1, 8'h02, 16'd8));
    tbl.push_back(mk(1, 0, 0, 8'h00, 1, 16'h0000, 8'h00, 0, 0, 0, 8'h00, 16'd0));
    tbl.push_back(mk(0, 0, 1, 8'h50, 0, 16'h0000, 8'h00, 0, 0, 0, 8'h00, 16'd0));
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 16'h1000, 8'h00, 1, 0, 0, 8'h02, 16'd1));
    tbl.push_back(mk(0, 1, 0, 8'h00, 0, 16'h1000, 8'h00, 1, 0, 0, 8'h02, 16'd1));
    tbl.push_back(mk(1, 1, 1, 8'h31, 0, 16'h0000, 8'h00, 0, 0, 0, 8'h00, 16'd0));
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 16'h0000, 8'h00, 0, 0, 0, 8'h00, 16'd0));
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 16'h1000, 8'h00, 1, 0, 0, 8'h02, 16'd1));
    tbl.push_back(mk(1, 0, 0, 8'h00, 0, 16'h0000, 8'h00, 0, 0, 0, 8'h00, 16'd0));
    tbl.push_back(mk(0, 0, 0, 8'h00, 1, 16'h0000, 8'h00, 0, 0, 1, 8'h00, 16'd0));
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 16'h0000, 8'h00, 0, 0, 1, 8'h00, 16'd0));

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].stall, tbl[i].redir, tbl[i].rpc, tbl[i].halt);
      chk($sformatf("vec%0d_ir", i),        32'(ir),        32'(tbl[i].ir));
      chk($sformatf("vec%0d_ir_pc", i),     32'(ir_pc),     32'(tbl[i].ir_pc));
      chk($sformatf("vec%0d_ir_valid", i),  32'(ir_valid),  32'(tbl[i].v));
      chk($sformatf("vec%0d_align_err", i), 32'(align_err), 32'(tbl[i].al));
      chk($sformatf("vec%0d_halted", i),    32'(halted),    32'(tbl[i].h));
      chk($sformatf("vec%0d_iaddr", i),     32'(iaddr),     32'(tbl[i].iaddr));
      chk($sformatf("vec%0d_fetch_cnt", i), 32'(fetch_cnt), 32'(tbl[i].cnt));
    end

    // Randomized phase against the reference model, with random memory contents.
    for (int k = 0; k < 128; k++) mem[k] = 16'($urandom);
    model_step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int n = 0; n < 4000; n++) begin
      logic       r_r, r_s, r_rd, r_h;
      logic [7:0] r_rp;
      r_r  = ($urandom_range(0, 149) == 0);
      r_h  = ($urandom_range(0, 79) == 0);
      r_rd = ($urandom_range(0, 9) == 0);
      r_s  = ($urandom_range(0, 3) == 0);
      r_rp = 8'($urandom);
      model_step(r_r, r_s, r_rd, r_rp, r_h);
      drive(r_r, r_s, r_rd, r_rp, r_h);
      chk($sformatf("rnd%0d_iaddr", n),     32'(iaddr),     32'(m_pc));
      chk($sformatf("rnd%0d_ir", n),        32'(ir),        32'(m_ir));
      chk($sformatf("rnd%0d_ir_pc", n),     32'(ir_pc),     32'(m_ir_pc));
      chk($sformatf("rnd%0d_ir_valid", n),  32'(ir_valid),  32'(m_v));
      chk($sformatf("rnd%0d_align_err", n), 32'(align_err), 32'(m_al));
      chk($sformatf("rnd%0d_halted", n),    32'(halted),    32'(m_halted));
      chk($sformatf("rnd%0d_fetch_cnt", n), 32'(fetch_cnt), 32'(m_cnt));
      chk($sformatf("rnd%0d_sat_cnt", n),   32'(fetch_cnt2), 32'((m_cnt > 7) ? 7 : m_cnt));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
